pc_sequencer: RTL

Parametrised program-counter sequencer. It holds the CPU's PC register and computes the next PC each cycle: sequential step, relative branch, absolute jump, or call/return. Call and return use an internal return-address stack (RAS). It replaces the bare combinational +1 incrementer and adds stall, control-flow redirect and buffering. It sits between the decode/branch logic and the instruction-memory address port.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_ras.sv | 60 ++++++
 rtl/pc_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select
// codes and a constant-evaluable ceiling-log2 helper.
package pc_defs;

  localparam logic [2:0] SEL_HOLD   = 3'd0;
  localparam logic [2:0] SEL_RET    = 3'd1;
  localparam logic [2:0] SEL_CALL   = 3'd2;
  localparam logic [2:0] SEL_JUMP   = 3'd3;
  localparam logic [2:0] SEL_BRANCH = 3'd4;
  localparam logic [2:0] SEL_SEQ    = 3'd5;

  // Bounded loop so it stays elaboration-friendly; valid for n up to 2^30.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: circular buffer whose oldest entry is silently
// overwritten when pushing into a full stack.
module pc_ras
  import pc_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PTR_W    = clog2(RAS_DEPTH),
  localparam int CNT_W    = clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [RAS_DEPTH];
  logic [PTR_W-1:0] top_reg;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;
  logic             do_push;

  // Explicit wrap so non-power-of-two depths work.
  assign top_inc = (top_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_reg + 1'b1;
  assign top_dec = (top_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : top_reg - 1'b1;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(RAS_DEPTH));
  assign count    = count_reg;
  assign top_data = mem_reg[top_dec];

  assign do_pop  = pop && !empty;
  assign do_push = push && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else if (do_pop) begin
      top_reg   <= top_dec;
      count_reg <= count_reg - 1'b1;
    end else if (do_push) begin
      top_reg <= top_inc;
      if (!full) count_reg <= count_reg + 1'b1;
    end
  end

  // Entry contents need no reset; kept separate from the pointer logic.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_reg[top_reg] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, priority next-PC select and
// return-address stack for call/return.
module pc_sequencer
  import pc_defs::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 1,
  parameter int               OFF_WIDTH = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               branch_en,
  input  logic [OFF_WIDTH-1:0]               branch_off,
  input  logic                               jump_en,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic [WIDTH-1:0]                   jump_addr,
  output logic [WIDTH-1:0]                   pc_out,
  output logic [WIDTH-1:0]                   pc_seq,
  output logic [clog2(RAS_DEPTH + 1)-1:0]    ras_count,
  output logic                               ras_empty,
  output logic                               ras_full,
  output logic                               ras_ovf,
  output logic                               ras_unf
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] ras_top;
  logic [2:0]       sel;
  logic             ras_ovf_reg;
  logic             ras_unf_reg;

  assign pc_seq  = pc_reg + WIDTH'(STEP);
  assign off_ext = {{(WIDTH - OFF_WIDTH){branch_off[OFF_WIDTH-1]}}, branch_off};

  always_comb begin
    sel = SEL_SEQ;
    if (stall)          sel = SEL_HOLD;
    else if (ret_en)    sel = SEL_RET;
    else if (call_en)   sel = SEL_CALL;
    else if (jump_en)   sel = SEL_JUMP;
    else if (branch_en) sel = SEL_BRANCH;
  end

  always_comb begin
    pc_next = pc_seq;
    case (sel)
      SEL_HOLD:   pc_next = pc_reg;
      SEL_RET:    pc_next = ras_empty ? pc_seq : ras_top;
      SEL_CALL,
      SEL_JUMP:   pc_next = jump_addr;
      SEL_BRANCH: pc_next = pc_reg + off_ext;
      default:    pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_VEC;
      ras_ovf_reg <= 1'b0;
      ras_unf_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      ras_ovf_reg <= (sel == SEL_CALL) && ras_full;
      ras_unf_reg <= (sel == SEL_RET) && ras_empty;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (sel == SEL_CALL),
    .pop       (sel == SEL_RET),
    .push_data (pc_seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc_out  = pc_reg;
  assign ras_ovf = ras_ovf_reg;
  assign ras_unf = ras_unf_reg;

endmodule
